// File: rtl/signed_round_sat_if.sv
// Sample bus for signed_round_sat: input sample/qualifier, counter clear,
// and the rounded/saturated output with its clip flag and event count.
interface signed_round_sat_if #(
    parameter int IWIDTH = 20,
    parameter int OWIDTH = 16,
    parameter int CWIDTH = 16
);
    logic                     i_valid;
    logic signed [IWIDTH-1:0] i_data;
    logic                     i_clr_ovf;
    logic                     o_valid;
    logic signed [OWIDTH-1:0] o_data;
    logic                     o_ovf;
    logic [CWIDTH-1:0]        o_ovf_count;

    modport master (
        output i_valid, i_data, i_clr_ovf,
        input  o_valid, o_data, o_ovf, o_ovf_count
    );

    modport slave (
        input  i_valid, i_data, i_clr_ovf,
        output o_valid, o_data, o_ovf, o_ovf_count
    );
endinterface

// File: rtl/signed_round_sat.sv
// Two-stage width reducer: convergent rounding of SHIFT LSBs, then signed
// saturation to OWIDTH bits, with a sticky-at-max clip event counter.
module signed_round_sat #(
    parameter int IWIDTH = 20,
    parameter int SHIFT  = 2,
    parameter int OWIDTH = 16,
    parameter int CWIDTH = 16
) (
    input logic              i_clk,
    input logic              i_reset,
    signed_round_sat_if.slave bus
);
    localparam int QW = IWIDTH - SHIFT;
    localparam int YW = QW + 1;
    localparam logic signed [YW-1:0] MAX_C = {{(YW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] MIN_C = {{(YW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
    localparam logic [CWIDTH-1:0]    CNT_MAX_C = '1;

    logic                     v1_q;
    logic signed [YW-1:0]     y_d, y_q;
    logic                     valid_q;
    logic signed [OWIDTH-1:0] data_d, data_q;
    logic                     ovf_d, ovf_q;
    logic [CWIDTH-1:0]        cnt_base_s, cnt_d, cnt_q;

    // Extra headroom bit on y keeps q+1 from wrapping at the positive rail.
    generate
        if (SHIFT == 0) begin : g_noshift
            // No fractional bits: pass the sample through sign-extended.
            always_comb begin
                y_d = {bus.i_data[IWIDTH-1], bus.i_data};
            end
        end else begin : g_round
            localparam logic signed [SHIFT:0] HALF_C = (SHIFT+1)'(1'b1) << (SHIFT-1);
            logic signed [QW-1:0]  q_s;
            logic signed [SHIFT:0] r_s;
            logic                  inc_s;

            // Floor quotient plus half-to-even increment decision.
            always_comb begin
                q_s = bus.i_data[IWIDTH-1:SHIFT];
                r_s = $signed({1'b0, bus.i_data[SHIFT-1:0]});
                if (r_s > HALF_C) begin
                    inc_s = 1'b1;
                end else if (r_s == HALF_C) begin
                    inc_s = q_s[0];
                end else begin
                    inc_s = 1'b0;
                end
                y_d = $signed({q_s[QW-1], q_s}) + $signed({{QW{1'b0}}, inc_s});
            end
        end
    endgenerate

    // Stage 1 register: rounded value loads only with a valid sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1_q <= 1'b0;
            y_q  <= '0;
        end else begin
            v1_q <= bus.i_valid;
            if (bus.i_valid) begin
                y_q <= y_d;
            end
        end
    end

    // Signed clamp to the OWIDTH range.
    always_comb begin
        if (y_q > MAX_C) begin
            data_d = MAX_C[OWIDTH-1:0];
            ovf_d  = 1'b1;
        end else if (y_q < MIN_C) begin
            data_d = MIN_C[OWIDTH-1:0];
            ovf_d  = 1'b1;
        end else begin
            data_d = y_q[OWIDTH-1:0];
            ovf_d  = 1'b0;
        end
    end

    // Stage 2 register: data holds between samples, clip flag only with valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= v1_q;
            ovf_q   <= v1_q & ovf_d;
            if (v1_q) begin
                data_q <= data_d;
            end
        end
    end

    // Clear is applied before the current event is counted.
    always_comb begin
        if (bus.i_clr_ovf) begin
            cnt_base_s = '0;
        end else begin
            cnt_base_s = cnt_q;
        end
        if (valid_q && ovf_q && (cnt_base_s != CNT_MAX_C)) begin
            cnt_d = cnt_base_s + CWIDTH'(1'b1);
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // Overflow event counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_ovf_count = cnt_q;
endmodule
